// File: rtl/rnf_cpu_port_if.sv
// rnf_cpu_port_if: CPU-side and RN-F internal request/response bundle.
// The slave view is the port endpoint; the master view drives it.
interface rnf_cpu_port_if;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic         cpu_req_read;
  logic [47:0]  cpu_req_addr;
  logic [3:0]   cpu_req_size;
  logic [511:0] cpu_req_data;
  logic [7:0]   cpu_req_qos;

  logic         cpu_rsp_valid;
  logic         cpu_rsp_ready;
  logic [511:0] cpu_rsp_data;
  logic         cpu_rsp_error;
  logic [11:0]  cpu_rsp_txn_id;

  logic         dn_req_valid;
  logic         dn_req_ready;
  logic         dn_req_read;
  logic [47:0]  dn_req_addr;
  logic [3:0]   dn_req_size;
  logic [511:0] dn_req_data;
  logic [7:0]   dn_req_qos;
  logic [11:0]  dn_req_txn_id;

  logic         dn_rsp_valid;
  logic         dn_rsp_ready;
  logic [511:0] dn_rsp_data;
  logic         dn_rsp_error;
  logic [11:0]  dn_rsp_txn_id;

  modport slave (
    input  cpu_req_valid,
    output cpu_req_ready,
    input  cpu_req_read,
    input  cpu_req_addr,
    input  cpu_req_size,
    input  cpu_req_data,
    input  cpu_req_qos,
    output cpu_rsp_valid,
    input  cpu_rsp_ready,
    output cpu_rsp_data,
    output cpu_rsp_error,
    output cpu_rsp_txn_id,
    output dn_req_valid,
    input  dn_req_ready,
    output dn_req_read,
    output dn_req_addr,
    output dn_req_size,
    output dn_req_data,
    output dn_req_qos,
    output dn_req_txn_id,
    input  dn_rsp_valid,
    output dn_rsp_ready,
    input  dn_rsp_data,
    input  dn_rsp_error,
    input  dn_rsp_txn_id
  );

  modport master (
    output cpu_req_valid,
    input  cpu_req_ready,
    output cpu_req_read,
    output cpu_req_addr,
    output cpu_req_size,
    output cpu_req_data,
    output cpu_req_qos,
    input  cpu_rsp_valid,
    output cpu_rsp_ready,
    input  cpu_rsp_data,
    input  cpu_rsp_error,
    input  cpu_rsp_txn_id,
    input  dn_req_valid,
    output dn_req_ready,
    input  dn_req_read,
    input  dn_req_addr,
    input  dn_req_size,
    input  dn_req_data,
    input  dn_req_qos,
    input  dn_req_txn_id,
    output dn_rsp_valid,
    input  dn_rsp_ready,
    output dn_rsp_data,
    output dn_rsp_error,
    output dn_rsp_txn_id
  );
endinterface

// File: rtl/rnf_cpu_port.sv
// rnf_cpu_port: CPU request/response endpoint at the front of the RN-F.
// Tags requests with a 12-bit ID, queues them, and bounds outstanding work.
module rnf_cpu_port #(
  parameter int REQ_DEPTH = 4,
  parameter int MAX_OUT   = 8,
  parameter int OW        = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  rnf_cpu_port_if.slave bus,
  output logic [OW-1:0] outstanding,
  output logic          spurious_rsp
);

  localparam int AW = $clog2(REQ_DEPTH);
  localparam logic [OW-1:0] MAX_C = OW'(MAX_OUT);

  typedef struct packed {
    logic         read;
    logic [47:0]  addr;
    logic [3:0]   size;
    logic [511:0] data;
    logic [7:0]   qos;
    logic [11:0]  id;
  } req_t;

  req_t         r_mem [REQ_DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [11:0]  r_next_id;
  logic [OW-1:0] r_out;
  logic         r_spur;

  logic         r_buf_valid;
  logic [511:0] r_buf_data;
  logic         r_buf_err;
  logic [11:0]  r_buf_id;

  logic         w_empty;
  logic         w_full;
  logic         w_req_ready;
  logic         w_push;
  logic         w_pop;
  logic         w_dn_rsp_ready;
  logic         w_rsp_load;
  logic         w_rsp_done;
  req_t         w_push_ent;
  req_t         w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Ready depends only on registered state: no pop-while-full bypass.
  assign w_req_ready = !w_full && (r_out < MAX_C);
  assign w_push      = bus.cpu_req_valid && w_req_ready;
  assign w_pop       = !w_empty && bus.dn_req_ready;

  assign w_push_ent.read = bus.cpu_req_read;
  assign w_push_ent.addr = bus.cpu_req_addr;
  assign w_push_ent.size = bus.cpu_req_size;
  assign w_push_ent.data = bus.cpu_req_data;
  assign w_push_ent.qos  = bus.cpu_req_qos;
  assign w_push_ent.id   = r_next_id;

  // Empty FIFO presents zeros so idle outputs never show stale entries.
  assign w_head = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  assign w_dn_rsp_ready = !r_buf_valid || bus.cpu_rsp_ready;
  assign w_rsp_load     = bus.dn_rsp_valid && w_dn_rsp_ready;
  assign w_rsp_done     = r_buf_valid && bus.cpu_rsp_ready;

  // Request storage; contents are only observed through the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_push_ent;
    end
  end

  // FIFO pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Transaction ID allocator, wraps 4095 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_id <= '0;
    end else if (w_push) begin
      r_next_id <= r_next_id + 12'd1;
    end
  end

  // Outstanding count: up on accept, down on CPU response, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_push && !w_rsp_done) begin
      if (r_out != MAX_C) begin
        r_out <= r_out + OW'(1);
      end
    end else if (!w_push && w_rsp_done) begin
      if (r_out != '0) begin
        r_out <= r_out - OW'(1);
      end
    end
  end

  // One-entry response buffer toward the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_buf_err   <= 1'b0;
      r_buf_id    <= '0;
    end else if (w_rsp_load) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= bus.dn_rsp_data;
      r_buf_err   <= bus.dn_rsp_error;
      r_buf_id    <= bus.dn_rsp_txn_id;
    end else if (w_rsp_done) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Sticky flag for a response nobody was waiting for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spur <= 1'b0;
    end else if (w_rsp_load && (r_out == '0) && !r_buf_valid) begin
      r_spur <= 1'b1;
    end
  end

  assign bus.cpu_req_ready  = w_req_ready;

  assign bus.dn_req_valid   = !w_empty;
  assign bus.dn_req_read    = w_head.read;
  assign bus.dn_req_addr    = w_head.addr;
  assign bus.dn_req_size    = w_head.size;
  assign bus.dn_req_data    = w_head.data;
  assign bus.dn_req_qos     = w_head.qos;
  assign bus.dn_req_txn_id  = w_head.id;

  assign bus.dn_rsp_ready   = w_dn_rsp_ready;

  assign bus.cpu_rsp_valid  = r_buf_valid;
  assign bus.cpu_rsp_data   = r_buf_data;
  assign bus.cpu_rsp_error  = r_buf_err;
  assign bus.cpu_rsp_txn_id = r_buf_id;

  assign outstanding  = r_out;
  assign spurious_rsp = r_spur;

endmodule

// File: tb/tb_rnf_cpu_port.sv
// tb_rnf_cpu_port: directed checks of the CPU port endpoint.
// Vector table for the streaming paths, hand sequences for corners.
module tb_rnf_cpu_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rnf_cpu_port_if if8();
  rnf_cpu_port_if if2();

  logic [3:0] out8;
  logic [1:0] out2;
  logic       spur8;
  logic       spur2;

  logic        echo = 1'b0;
  logic        t_drv = 1'b0;
  logic [11:0] t_did = '0;

  assign if8.dn_rsp_valid  = echo ? if8.dn_req_valid  : t_drv;
  assign if8.dn_rsp_txn_id = echo ? if8.dn_req_txn_id : t_did;

  rnf_cpu_port #(.REQ_DEPTH(4), .MAX_OUT(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave),
    .outstanding(out8), .spurious_rsp(spur8)
  );

  rnf_cpu_port #(.REQ_DEPTH(4), .MAX_OUT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave),
    .outstanding(out2), .spurious_rsp(spur2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [47:0] addr;
    logic        dnr;
    logic        crr;
    logic        drv;
    logic [11:0] did;
    logic        e_rdy;
    logic        e_dnv;
    logic [11:0] e_txn;
    logic [47:0] e_addr;
    int          e_out;
    logic        e_rv;
    logic [11:0] e_rid;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic rst, logic rv, logic [47:0] addr, logic dnr, logic crr,
    logic drv, logic [11:0] did, logic e_rdy, logic e_dnv,
    logic [11:0] e_txn, logic [47:0] e_addr, int e_out,
    logic e_rv, logic [11:0] e_rid);
    vec_t v;
    v.rst = rst; v.rv = rv; v.addr = addr; v.dnr = dnr;
    v.crr = crr; v.drv = drv; v.did = did; v.e_rdy = e_rdy;
    v.e_dnv = e_dnv; v.e_txn = e_txn; v.e_addr = e_addr;
    v.e_out = e_out; v.e_rv = e_rv; v.e_rid = e_rid;
    return v;
  endfunction

  initial begin
    int bad;

    // Three back-to-back reads, then out-of-order responses.
    tv.push_back(mk(0,1,'h1000,1,1,0,0, 1,0,0,0,      0,0,0));
    tv.push_back(mk(0,1,'h1040,1,1,0,0, 1,1,0,'h1000, 1,0,0));
    tv.push_back(mk(0,1,'h1080,1,1,0,0, 1,1,1,'h1040, 2,0,0));
    tv.push_back(mk(0,0,0,     1,1,0,0, 1,1,2,'h1080, 3,0,0));
    tv.push_back(mk(0,0,0,     0,1,1,0, 1,0,0,0,      3,0,0));
    tv.push_back(mk(0,0,0,     0,1,1,2, 1,0,0,0,      3,1,0));
    tv.push_back(mk(0,0,0,     0,1,1,1, 1,0,0,0,      2,1,2));
    tv.push_back(mk(0,0,0,     0,1,0,0, 1,0,0,0,      1,1,1));
    tv.push_back(mk(0,0,0,     0,1,0,0, 1,0,0,0,      0,0,0));
    // Blocked downstream: FIFO fills at 4, then drains in order.
    tv.push_back(mk(1,1,'h2000,0,1,0,0, 1,0,0,0,      0,0,0));
    tv.push_back(mk(0,1,'h2040,0,1,0,0, 1,1,0,'h2000, 1,0,0));
    tv.push_back(mk(0,1,'h2080,0,1,0,0, 1,1,0,'h2000, 2,0,0));
    tv.push_back(mk(0,1,'h20C0,0,1,0,0, 1,1,0,'h2000, 3,0,0));
    tv.push_back(mk(0,1,'h2100,0,1,0,0, 0,1,0,'h2000, 4,0,0));
    tv.push_back(mk(0,1,'h2100,1,1,0,0, 0,1,0,'h2000, 4,0,0));
    tv.push_back(mk(0,1,'h2100,1,1,0,0, 1,1,1,'h2040, 4,0,0));
    tv.push_back(mk(0,1,'h2140,1,1,0,0, 1,1,2,'h2080, 5,0,0));
    tv.push_back(mk(0,0,0,     1,1,0,0, 1,1,3,'h20C0, 6,0,0));
    tv.push_back(mk(0,0,0,     1,1,0,0, 1,1,4,'h2100, 6,0,0));
    tv.push_back(mk(0,0,0,     1,1,0,0, 1,1,5,'h2140, 6,0,0));
    tv.push_back(mk(0,0,0,     0,1,0,0, 1,0,0,0,      6,0,0));

    if8.cpu_req_valid = 0; if8.cpu_req_read = 1;
    if8.cpu_req_addr = '0; if8.cpu_req_size = 4'h3;
    if8.cpu_req_data = '0; if8.cpu_req_qos = 8'h1;
    if8.cpu_rsp_ready = 0; if8.dn_req_ready = 0;
    if8.dn_rsp_data = '0; if8.dn_rsp_error = 0;
    if2.cpu_req_valid = 0; if2.cpu_req_read = 0;
    if2.cpu_req_addr = '0; if2.cpu_req_size = '0;
    if2.cpu_req_data = '0; if2.cpu_req_qos = '0;
    if2.cpu_rsp_ready = 0; if2.dn_req_ready = 0;
    if2.dn_rsp_valid = 0; if2.dn_rsp_data = '0;
    if2.dn_rsp_error = 0; if2.dn_rsp_txn_id = '0;

    #12;
    chk("rst.req_ready", if8.cpu_req_ready, 1);
    chk("rst.dn_valid", if8.dn_req_valid, 0);
    chk("rst.dn_txn", if8.dn_req_txn_id, 0);
    chk("rst.rsp_valid", if8.cpu_rsp_valid, 0);
    chk("rst.rsp_data", if8.cpu_rsp_data, 0);
    chk("rst.rsp_id", if8.cpu_rsp_txn_id, 0);
    chk("rst.out8", out8, 0);
    chk("rst.spur8", spur8, 0);
    chk("rst.out2", out2, 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) apply_reset();
      if8.cpu_req_valid = tv[i].rv;
      if8.cpu_req_addr  = tv[i].addr;
      if8.dn_req_ready  = tv[i].dnr;
      if8.cpu_rsp_ready = tv[i].crr;
      t_drv = tv[i].drv;
      t_did = tv[i].did;
      #1;
      chk($sformatf("v%0d.req_ready", i), if8.cpu_req_ready, tv[i].e_rdy);
      chk($sformatf("v%0d.dn_valid", i), if8.dn_req_valid, tv[i].e_dnv);
      if (tv[i].e_dnv) begin
        chk($sformatf("v%0d.dn_txn", i), if8.dn_req_txn_id, tv[i].e_txn);
        chk($sformatf("v%0d.dn_addr", i), if8.dn_req_addr, tv[i].e_addr);
      end
      chk($sformatf("v%0d.out", i), out8, tv[i].e_out);
      chk($sformatf("v%0d.rsp_valid", i), if8.cpu_rsp_valid, tv[i].e_rv);
      if (tv[i].e_rv) begin
        chk($sformatf("v%0d.rsp_id", i), if8.cpu_rsp_txn_id, tv[i].e_rid);
      end
      cyc();
    end
    if8.cpu_req_valid = 0; if8.dn_req_ready = 0;
    if8.cpu_rsp_ready = 0; t_drv = 0;

    // MAX_OUT=2 limit and an error response.
    if2.cpu_req_valid = 1; if2.cpu_req_addr = 'h3000;
    if2.cpu_req_size = 4'h6; if2.cpu_req_qos = 8'h5A;
    if2.cpu_req_data = {16{32'hDEADBEEF}};
    if2.cpu_rsp_ready = 1;
    #1;
    chk("m2.ready0", if2.cpu_req_ready, 1);
    cyc();
    chk("m2.dn_valid", if2.dn_req_valid, 1);
    chk("m2.dn_read", if2.dn_req_read, 0);
    chk("m2.dn_size", if2.dn_req_size, 4'h6);
    chk("m2.dn_qos", if2.dn_req_qos, 8'h5A);
    chk("m2.dn_data", if2.dn_req_data, {16{32'hDEADBEEF}});
    chk("m2.ready1", if2.cpu_req_ready, 1);
    cyc();
    chk("m2.out_full", out2, 2);
    chk("m2.ready_lim", if2.cpu_req_ready, 0);
    if2.cpu_req_valid = 0;
    if2.dn_req_ready = 1;
    if2.dn_rsp_valid = 1; if2.dn_rsp_txn_id = 12'd1;
    if2.dn_rsp_data = {64{8'hA5}}; if2.dn_rsp_error = 1;
    #1;
    chk("m2.dn_rsp_ready", if2.dn_rsp_ready, 1);
    cyc();
    if2.dn_rsp_valid = 0;
    #1;
    chk("m2.rsp_valid", if2.cpu_rsp_valid, 1);
    chk("m2.rsp_id", if2.cpu_rsp_txn_id, 1);
    chk("m2.rsp_err", if2.cpu_rsp_error, 1);
    chk("m2.rsp_data", if2.cpu_rsp_data, {64{8'hA5}});
    chk("m2.out_hold", out2, 2);
    cyc();
    chk("m2.out_dec", out2, 1);
    chk("m2.ready_back", if2.cpu_req_ready, 1);
    chk("m2.rsp_clr", if2.cpu_rsp_valid, 0);

    // Response backpressure: second response waits, order kept.
    if2.cpu_rsp_ready = 0;
    if2.dn_rsp_valid = 1; if2.dn_rsp_txn_id = 12'd7;
    if2.dn_rsp_data = 512'h1111; if2.dn_rsp_error = 0;
    #1;
    chk("bp.ready_a", if2.dn_rsp_ready, 1);
    cyc();
    if2.dn_rsp_txn_id = 12'd9;
    if2.dn_rsp_data = 512'h2222; if2.dn_rsp_error = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("bp%0d.dn_ready", k), if2.dn_rsp_ready, 0);
      chk($sformatf("bp%0d.id", k), if2.cpu_rsp_txn_id, 7);
      chk($sformatf("bp%0d.data", k), if2.cpu_rsp_data, 512'h1111);
      chk($sformatf("bp%0d.err", k), if2.cpu_rsp_error, 0);
      cyc();
    end
    if2.cpu_rsp_ready = 1;
    #1;
    chk("bp.ready_b", if2.dn_rsp_ready, 1);
    cyc();
    if2.dn_rsp_valid = 0;
    #1;
    chk("bp.id_b", if2.cpu_rsp_txn_id, 9);
    chk("bp.data_b", if2.cpu_rsp_data, 512'h2222);
    chk("bp.err_b", if2.cpu_rsp_error, 1);
    chk("bp.out0", out2, 0);
    cyc();
    chk("bp.done", if2.cpu_rsp_valid, 0);
    chk("bp.out_sat", out2, 0);
    chk("bp.spur", spur2, 0);

    // ID wrap across 4096 streamed transactions.
    apply_reset();
    if8.cpu_req_valid = 1; if8.cpu_req_addr = 'h4000;
    if8.dn_req_ready = 1; if8.cpu_rsp_ready = 1;
    echo = 1;
    bad = 0;
    for (int k = 0; k < 4097; k++) begin
      cyc();
      if (!(if8.dn_req_valid && if8.dn_req_txn_id == 12'(k))) bad++;
      if (k == 4095) chk("wrap.id4095", if8.dn_req_txn_id, 12'd4095);
      if (k == 4096) chk("wrap.id0", if8.dn_req_txn_id, 12'd0);
    end
    chk("wrap.id_seq", bad, 0);
    if8.cpu_req_valid = 0;
    repeat (4) cyc();
    chk("wrap.out_drain", out8, 0);
    chk("wrap.spur0", spur8, 0);
    echo = 0;

    // Unsolicited response sets the sticky flag and still passes.
    t_drv = 1; t_did = 12'h123;
    #1;
    chk("sp.dn_ready", if8.dn_rsp_ready, 1);
    cyc();
    t_drv = 0;
    #1;
    chk("sp.flag", spur8, 1);
    chk("sp.rsp_valid", if8.cpu_rsp_valid, 1);
    chk("sp.rsp_id", if8.cpu_rsp_txn_id, 12'h123);
    cyc();
    chk("sp.out", out8, 0);
    chk("sp.sticky", spur8, 1);

    // Asynchronous reset with two queued requests.
    if8.dn_req_ready = 0; if8.cpu_rsp_ready = 0;
    if8.cpu_req_valid = 1; if8.cpu_req_addr = 'h5000;
    t_drv = 1; t_did = 12'h044;
    cyc();
    t_drv = 0;
    cyc();
    if8.cpu_req_valid = 0;
    #1;
    chk("ar.pre_dnv", if8.dn_req_valid, 1);
    chk("ar.pre_out", out8, 2);
    chk("ar.pre_rsp", if8.cpu_rsp_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar.dnv", if8.dn_req_valid, 0);
    chk("ar.rsp", if8.cpu_rsp_valid, 0);
    chk("ar.out", out8, 0);
    chk("ar.spur", spur8, 0);
    rst_n = 1'b1;
    if8.cpu_rsp_ready = 1;
    if8.cpu_req_valid = 1;
    cyc();
    if8.cpu_req_valid = 0;
    #1;
    chk("ar.dnv_new", if8.dn_req_valid, 1);
    chk("ar.id_restart", if8.dn_req_txn_id, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
